// File: rtl/mod_pkg.sv
// Shared constants for the QPSK modulator: sample LUT, symbol codes, FSM states.
package mod_pkg;

  localparam int N_SAMPLES = 32;
  localparam logic [7:0] MIDSCALE = 8'h40;

  localparam logic [1:0] SYM_SIN  = 2'b00;
  localparam logic [1:0] SYM_COS  = 2'b01;
  localparam logic [1:0] SYM_NSIN = 2'b11;
  localparam logic [1:0] SYM_NCOS = 2'b10;

  typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, DATA, TAIL} state_t;

  // One carrier period around midscale 8'h40, peak 8'h80, trough 8'h00.
  localparam logic [7:0] SIN_LUT [0:N_SAMPLES-1] = '{
    8'h40, 8'h4C, 8'h58, 8'h64, 8'h6D, 8'h75, 8'h7B, 8'h7F,
    8'h80, 8'h7F, 8'h7B, 8'h75, 8'h6D, 8'h64, 8'h58, 8'h4C,
    8'h40, 8'h34, 8'h28, 8'h1C, 8'h13, 8'h0B, 8'h05, 8'h01,
    8'h00, 8'h01, 8'h05, 8'h0B, 8'h13, 8'h1C, 8'h28, 8'h34
  };

endpackage

// File: rtl/mod_wave_lut.sv
// Combinational (sym, idx) -> carrier sample; zero latency, no backpressure.
// Cosine is the sine table advanced a quarter period; inversion mirrors about 8'h40.
module mod_wave_lut
  import mod_pkg::*;
(
  input  logic [1:0] sym,
  input  logic [4:0] idx,
  output logic [7:0] sample
);

  logic [4:0] k;
  logic [7:0] base;

  always_comb begin
    k = idx;
    if (sym == SYM_COS || sym == SYM_NCOS) begin
      k = idx + 5'd8;
    end
    base   = SIN_LUT[k];
    sample = base;
    if (sym == SYM_NSIN || sym == SYM_NCOS) begin
      sample = 8'h80 - base;
    end
  end

endmodule

// File: rtl/qpsk_modulator.sv
// QPSK frame modulator: header (sine preamble + inverted-sine sync) then data symbols, 32 samples each.
// Output registered one cycle behind the FSM; a symbol is taken only on the idx=31 sym_ready cycle. MOD_TAIL_EN adds a midscale tail.
module qpsk_modulator
  import mod_pkg::*;
#(
  parameter int PREAMBLE_SYMS = 4
`ifdef MOD_TAIL_EN
  ,
  parameter int TAIL_SYMS = 2
`endif
) (
  input  logic       clk_fast,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic [7:0] wav_out,
  output logic       wav_valid,
  output logic       busy
);

  localparam logic [4:0] IDX_LAST = 5'(N_SAMPLES - 1);
  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_SYMS - 1);

  state_t     state;
  logic [4:0] idx;
  logic [3:0] pre_cnt;
  logic [1:0] cur_sym;
  logic [1:0] lut_sym;
  logic [7:0] lut_sample;
  logic       emitting;

`ifdef MOD_TAIL_EN
  localparam logic [7:0] TAIL_LAST = 8'(TAIL_SYMS - 1);
  logic [7:0] tail_cnt;
`endif

  assign sym_ready = (state == SYNC || state == DATA) && (idx == IDX_LAST);
  assign busy      = (state != IDLE);
  assign emitting  = (state == PREAMBLE || state == SYNC || state == DATA);

  always_comb begin
    case (state)
      PREAMBLE: lut_sym = SYM_SIN;
      SYNC:     lut_sym = SYM_NSIN;
      default:  lut_sym = cur_sym;
    endcase
  end

  mod_wave_lut u_lut (
    .sym    (lut_sym),
    .idx    (idx),
    .sample (lut_sample)
  );

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 5'd0;
      pre_cnt   <= 4'd0;
      cur_sym   <= SYM_SIN;
      wav_out   <= MIDSCALE;
      wav_valid <= 1'b0;
`ifdef MOD_TAIL_EN
      tail_cnt  <= 8'd0;
`endif
    end else begin
      wav_valid <= (state != IDLE);
      wav_out   <= emitting ? lut_sample : MIDSCALE;
      if (state != IDLE) begin
        idx <= idx + 5'd1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= PREAMBLE;
            idx     <= 5'd0;
            pre_cnt <= 4'd0;
          end
        end
        PREAMBLE: begin
          if (idx == IDX_LAST) begin
            pre_cnt <= pre_cnt + 4'd1;
            if (pre_cnt == PRE_LAST) begin
              state <= SYNC;
            end
          end
        end
        SYNC, DATA: begin
          // Symbol boundary: an absent symbol here ends the frame.
          if (idx == IDX_LAST) begin
            if (sym_valid) begin
              cur_sym <= sym_in;
              state   <= DATA;
            end else begin
`ifdef MOD_TAIL_EN
              state    <= TAIL;
              tail_cnt <= 8'd0;
`else
              state <= IDLE;
`endif
            end
          end
        end
`ifdef MOD_TAIL_EN
        TAIL: begin
          if (idx == IDX_LAST) begin
            tail_cnt <= tail_cnt + 8'd1;
            if (tail_cnt == TAIL_LAST) begin
              state <= IDLE;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
